// File: rtl/seg_scroll_driver.sv
// ============================================================================
// Module   : seg_scroll_driver
// Purpose  : 16-entry segment message buffer, 8-digit scan and left scroll.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scroll_driver #(
   parameter int         FRAMES_PER_STEP = 64,
   parameter logic [7:0] BLANK_PAT       = 8'hFF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Tick,
   input  logic       Wr_En,
   input  logic [3:0] Wr_Addr,
   input  logic [7:0] Wr_Data,
   input  logic [4:0] Msg_Len,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Freeze,
   output logic [7:0] Anode,
   output logic [7:0] Display,
   output logic       Step,
   output logic       Wrap
);

   localparam logic [7:0] c_LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t     r_state;
   logic [2:0] r_digit;
   logic [7:0] r_frame_cnt;
   logic [3:0] r_offset;
   logic [4:0] r_len;
   logic [3:0] r_base;
   logic [3:0] r_ptr;
   logic [7:0] r_anode;
   logic [7:0] r_display;
   logic       r_step;
   logic       r_wrap;
   logic [7:0] r_buf [16];

   logic       w_len_ok;
   logic [3:0] w_start_base;
   logic [3:0] w_off_inc;
   logic [3:0] w_base_inc;
   logic [3:0] w_ptr_dec;

   // 7 mod len by repeated conditional subtract; len is at least 1.
   function automatic logic [3:0] f_seven_mod(input logic [4:0] len);
      logic [4:0] v;
      v = 5'd7;
      for (int k = 0; k < 7; k++) begin
         if (v >= len) v = v - len;
      end
      return v[3:0];
   endfunction

   function automatic logic [3:0] f_inc(input logic [3:0] x, input logic [4:0] len);
      logic [4:0] s;
      s = {1'b0, x} + 5'd1;
      if (s >= len) s = s - len;
      return s[3:0];
   endfunction

   function automatic logic [3:0] f_dec(input logic [3:0] x, input logic [4:0] len);
      logic [4:0] s;
      s = (x == 4'd0) ? (len - 5'd1) : ({1'b0, x} - 5'd1);
      return s[3:0];
   endfunction

   assign w_len_ok     = (Msg_Len != 5'd0) && (Msg_Len <= 5'd16);
   assign w_start_base = f_seven_mod(Msg_Len);
   assign w_off_inc    = f_inc(r_offset, r_len);
   assign w_base_inc   = f_inc(r_base, r_len);
   assign w_ptr_dec    = f_dec(r_ptr, r_len);

   always_ff @(posedge Clk) begin
      if (Wr_En) r_buf[Wr_Addr] <= Wr_Data;
   end

   // r_base is the buffer index of digit 0 for the current offset; r_ptr
   // walks down from it as the scan moves toward the leftmost digit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_digit     <= 3'd0;
         r_frame_cnt <= 8'd0;
         r_offset    <= 4'd0;
         r_len       <= 5'd0;
         r_base      <= 4'd0;
         r_ptr       <= 4'd0;
         r_anode     <= 8'hFF;
         r_display   <= BLANK_PAT;
         r_step      <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_step <= 1'b0;
         r_wrap <= 1'b0;
         if (Stop) begin
            r_state     <= S_IDLE;
            r_digit     <= 3'd0;
            r_frame_cnt <= 8'd0;
            r_offset    <= 4'd0;
            r_len       <= 5'd0;
            r_base      <= 4'd0;
            r_ptr       <= 4'd0;
            r_anode     <= 8'hFF;
            r_display   <= BLANK_PAT;
         end else if (Start && w_len_ok) begin
            r_state     <= S_RUN;
            r_digit     <= 3'd0;
            r_frame_cnt <= 8'd0;
            r_offset    <= 4'd0;
            r_len       <= Msg_Len;
            r_base      <= w_start_base;
            r_ptr       <= w_start_base;
            r_anode     <= 8'hFF;
            r_display   <= BLANK_PAT;
         end else if (r_state != S_IDLE) begin
            r_state <= Freeze ? S_HOLD : S_RUN;
            if (Tick) begin
               r_anode   <= ~(8'h01 << r_digit);
               r_display <= r_buf[r_ptr];
               r_digit   <= r_digit + 3'd1;
               if (r_digit != 3'd7) begin
                  r_ptr <= w_ptr_dec;
               end else if (Freeze) begin
                  r_ptr <= r_base;
               end else if (r_frame_cnt == c_LAST_FRAME) begin
                  r_frame_cnt <= 8'd0;
                  r_offset    <= w_off_inc;
                  r_base      <= w_base_inc;
                  r_ptr       <= w_base_inc;
                  r_step      <= 1'b1;
                  r_wrap      <= (w_off_inc == 4'd0);
               end else begin
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_ptr       <= r_base;
               end
            end
         end
      end
   end

   assign Anode   = r_anode;
   assign Display = r_display;
   assign Step    = r_step;
   assign Wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_seg_scroll_driver.sv
// ============================================================================
// Module   : tb_seg_scroll_driver
// Purpose  : Scoreboard bench for seg_scroll_driver (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scroll_driver;

   localparam int FPS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'd0;
   logic [7:0] wr_data = 8'd0;
   logic [4:0] msg_len = 5'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       freeze = 1'b0;
   logic [7:0] anode;
   logic [7:0] display;
   logic       step;
   logic       wrap;

   always #5 clk = ~clk;

   seg_scroll_driver #(
      .FRAMES_PER_STEP(FPS),
      .BLANK_PAT      (8'hFF)
   ) dut (
      .Clk    (clk),
      .Reset  (rst),
      .Tick   (tick),
      .Wr_En  (wr_en),
      .Wr_Addr(wr_addr),
      .Wr_Data(wr_data),
      .Msg_Len(msg_len),
      .Start  (start),
      .Stop   (stop),
      .Freeze (freeze),
      .Anode  (anode),
      .Display(display),
      .Step   (step),
      .Wrap   (wrap)
   );

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] dsp;
      logic       st;
      logic       wr;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       tick_q = 1'b0;
   logic [7:0] mem [16];
   int         m_run = 0, m_len = 1, m_off = 0, m_digit = 0, m_frame = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: digit d shows mem[(offset + 7 - d) % len].
   task automatic model_step(output exp_t e);
      e.an  = 8'hFF;
      e.dsp = 8'hFF;
      e.st  = 1'b0;
      e.wr  = 1'b0;
      if (m_run != 0) begin
         e.an  = ~(8'h01 << m_digit);
         e.dsp = mem[(m_off + 7 - m_digit) % m_len];
         if (m_digit == 7 && !freeze) begin
            if (m_frame == FPS - 1) begin
               m_frame = 0;
               m_off   = (m_off + 1) % m_len;
               e.st    = 1'b1;
               e.wr    = (m_off == 0);
            end else begin
               m_frame++;
            end
         end
         m_digit = (m_digit + 1) % 8;
      end
   endtask

   task automatic model_clear();
      m_run = 0; m_off = 0; m_digit = 0; m_frame = 0;
   endtask

   task automatic tick_push(input exp_t e);
      tick = 1'b1;
      q.push_back(e);
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic tick_model();
      exp_t e;
      model_step(e);
      tick_push(e);
   endtask

   task automatic tick_hand(input logic [7:0] an, input logic [7:0] dsp, input logic st, input logic wr);
      exp_t d, e;
      model_step(d);
      e.an = an; e.dsp = dsp; e.st = st; e.wr = wr;
      tick_push(e);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      mem[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_start(input int l);
      start = 1'b1;
      msg_len = 5'(l);
      if (l >= 1 && l <= 16) begin
         model_clear();
         m_run = 1;
         m_len = l;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      model_clear();
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic chk_blank(input string nm);
      chk({nm, "_anode"}, {24'd0, anode}, 32'hFF);
      chk({nm, "_display"}, {24'd0, display}, 32'hFF);
      chk({nm, "_step"}, {31'd0, step}, 32'd0);
      chk({nm, "_wrap"}, {31'd0, wrap}, 32'd0);
   endtask

   always @(posedge clk) tick_q <= tick;

   always @(negedge clk) begin
      if (tick_q) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: DUT output with no expected entry at %0t", $time);
         end else begin
            mon_e = q.pop_front();
            chk("anode", {24'd0, anode}, {24'd0, mon_e.an});
            chk("display", {24'd0, display}, {24'd0, mon_e.dsp});
            chk("step", {31'd0, step}, {31'd0, mon_e.st});
            chk("wrap", {31'd0, wrap}, {31'd0, mon_e.wr});
         end
      end else begin
         chk("idle_step", {31'd0, step}, 32'd0);
         chk("idle_wrap", {31'd0, wrap}, 32'd0);
      end
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] dsp8    [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
   logic [7:0] dsp3    [8] = '{8'h22, 8'h11, 8'h33, 8'h22, 8'h11, 8'h33, 8'h22, 8'h11};
   logic [7:0] msg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

   initial begin
      // Reset and idle behaviour
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_blank("reset");
      repeat (3) tick_model();

      // Eight-character message, first frame
      for (int i = 0; i < 8; i++) wr(4'(i), msg_tab[i]);
      do_start(8);
      for (int i = 0; i < 8; i++) tick_hand(an_tab[i], dsp8[i], 1'b0, 1'b0);

      // Scroll steps up to the first wrap
      for (int i = 9; i <= 128; i++) begin
         if (i == 16)       tick_hand(8'h7F, 8'hC0, 1'b1, 1'b0);
         else if (i == 24)  tick_hand(8'h7F, 8'hF9, 1'b0, 1'b0);
         else if (i == 128) tick_hand(8'h7F, 8'hF8, 1'b1, 1'b1);
         else               tick_model();
      end

      // Short message repeats across the digits
      wr(4'd0, 8'h11);
      wr(4'd1, 8'h22);
      wr(4'd2, 8'h33);
      do_start(3);
      for (int i = 0; i < 8; i++) tick_hand(an_tab[i], dsp3[i], 1'b0, 1'b0);
      do_stop();
      chk_blank("stop");
      do_start(0);
      tick_hand(8'hFF, 8'hFF, 1'b0, 1'b0);
      do_start(17);
      tick_hand(8'hFF, 8'hFF, 1'b0, 1'b0);

      // Freeze across a step boundary
      do_start(8);
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) tick_hand(8'h7F, 8'h11, 1'b1, 1'b0);
         else         tick_model();
      end
      freeze = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) tick_hand(8'h7F, 8'h22, 1'b0, 1'b0);
         else         tick_model();
      end
      freeze = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) tick_hand(8'h7F, 8'h22, 1'b1, 1'b0);
         else         tick_model();
      end

      // Stop and Start together: Stop wins
      repeat (3) tick_model();
      stop = 1'b1; start = 1'b1; msg_len = 5'd8;
      model_clear();
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      chk_blank("stop_start");
      tick_model();

      // Write to the address about to be displayed
      do_start(8);
      repeat (3) tick_model();
      wr(4'd4, 8'h5A);
      tick_hand(8'hF7, 8'h5A, 1'b0, 1'b0);

      // Reset mid-run keeps the buffer
      repeat (2) tick_model();
      rst = 1'b1;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      chk_blank("mid_reset");
      do_start(8);
      for (int i = 0; i < 8; i++) begin
         if (i == 0)      tick_hand(8'hFE, 8'hF8, 1'b0, 1'b0);
         else if (i == 3) tick_hand(8'hF7, 8'h5A, 1'b0, 1'b0);
         else             tick_model();
      end

      @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seg_scroll_driver.md
Name: seg_scroll_driver

Overview:
- Upstream stage for the 8-digit seven-segment display path.
- Holds a 16-entry message buffer of raw segment patterns and time-multiplexes it onto the anode/segment lines, one digit per refresh tick.
- Scrolls the message left by one character every FRAMES_PER_STEP complete refresh frames.
- Clocked by the board clock; refresh rate comes from a one-cycle Tick enable supplied by the clock-divider stage.

Parameters:
- FRAMES_PER_STEP, 64, full 8-digit refresh frames per scroll step (range 1..255).
- BLANK_PAT, 8'hFF, segment pattern driven when idle (active-low segments, all off).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Tick  input  1  one-cycle refresh enable; advances the digit scan.
- Wr_En  input  1  write strobe into the message buffer.
- Wr_Addr  input  4  message buffer write address, 0..15.
- Wr_Data  input  8  segment pattern to write (active-low, bit 7 = dp).
- Msg_Len  input  5  message length in characters, valid 1..16; sampled on Start.
- Start  input  1  pulse: begin or restart scrolling.
- Stop  input  1  pulse: return to idle and blank the display.
- Freeze  input  1  level: hold the scroll offset while refresh continues.
- Anode  output  8  active-low digit enables, one-hot low in RUN/HOLD.
- Display  output  8  active-low segment pattern for the selected digit.
- Step  output  1  one-cycle pulse when the scroll offset advances.
- Wrap  output  1  one-cycle pulse when the offset wraps to 0.

Behaviour:
- Reset and polarity: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values:
  - state=IDLE; digit=0, frame_cnt=0, offset=0, len=0.
  - Anode=8'hFF, Display=BLANK_PAT, Step=0, Wrap=0.
  - Buffer contents are not reset; they are undefined until written.
- Priority per cycle: Reset > Stop > Start > Freeze/Tick.
- Buffer writes:
  - When Wr_En=1, buf[Wr_Addr] is written at the clock edge, in any state.
  - A write to an address being read in the same cycle returns the old data; the new data is visible from the next Tick.
- IDLE:
  - Anode=8'hFF, Display=BLANK_PAT.
  - Start with Msg_Len in 1..16: latch len=Msg_Len, set offset=0, digit=0, frame_cnt=0, go to RUN.
  - Start with Msg_Len=0 or >16 is ignored; state stays IDLE.
- RUN, on each Tick:
  - digit increments modulo 8.
  - On the 7->0 wrap, frame_cnt increments.
  - When frame_cnt=FRAMES_PER_STEP-1 and digit wraps: frame_cnt=0, offset=(offset+1) mod len, Step=1 for one cycle.
  - If the new offset is 0, Wrap=1 in the same cycle.
  - No change occurs on cycles without Tick.
- HOLD:
  - Entered from RUN when Freeze=1; returns to RUN when Freeze=0.
  - Digit scan continues.
  - frame_cnt and offset hold; Step and Wrap stay 0.
- Character mapping:
  - Digit d (Anode[d] low) shows buf[(offset + 7 - d) mod len]; digit 7 is leftmost.
  - When len<8, characters repeat cyclically across the digits.
- Output latency:
  - Anode and Display are registered and update one Clk after the Tick that changes digit or offset.
  - Anode and Display always change together; no glitch frame exists where the anode and pattern mismatch.
- Stop in RUN/HOLD: next cycle state=IDLE, Anode=8'hFF, Display=BLANK_PAT; counters are cleared.
- Start in RUN/HOLD restarts scrolling: re-latch len, offset=0, digit=0, frame_cnt=0, state=RUN.
- Msg_Len changes outside a Start pulse have no effect.
- Modulo arithmetic uses a 5-bit add with conditional subtract of len; no divider.
- Reset asserted mid-operation returns all state to the reset values on that edge; buffer contents are retained.

Test Plan:
- Reset held 2 cycles, then released -> Anode=8'hFF, Display=8'hFF, Step=0, Wrap=0; Tick pulses cause no change while IDLE.
- Write buf[0..7]=8'hC0,F9,A4,B0,99,92,82,F8; Msg_Len=8; Start; 8 Ticks (FRAMES_PER_STEP=64) -> Anode sequence FE,FD,FB,F7,EF,DF,BF,7F, one Clk after each Tick; Display sequence F8,82,92,99,B0,A4,F9,C0.
- FRAMES_PER_STEP=2, len=8: after 16 Ticks -> Step pulses once; digit 7 then shows F9 (buf[1]). After 128 Ticks -> offset=0 and Wrap pulses together with Step.
- len=3, buf[0..2]=11,22,33, offset=0 -> digits 7..0 show 11,22,33,11,22,33,11,22. Start with Msg_Len=0 -> remains IDLE with outputs blank.
- Freeze=1 across a step boundary -> scan continues, no Step, offset unchanged. Freeze=0 -> Step fires after FRAMES_PER_STEP further frames.
- Stop and Start asserted in the same cycle during RUN -> IDLE with blank outputs. Wr_En to the displayed address -> new pattern appears on the next Tick. Reset mid-RUN -> outputs blank the next cycle and buffer data is retained.
